// File: rtl/monitor_readout_ctrl.sv
// Histogram readout controller: snapshots two bin banks on a trigger and
// streams them as tagged 32-bit words followed by a sequence/drop trailer.
module monitor_readout_ctrl #(
  parameter int NUM_BINS = 16,
  parameter int CNT_SIZE = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         end_program,
  input  logic                         host_req,
  input  logic [NUM_BINS*CNT_SIZE-1:0] addr_bins,
  input  logic [NUM_BINS*CNT_SIZE-1:0] vctr_bins,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
);

  localparam int IW = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND_A   = 2'd1;
  localparam logic [1:0] SEND_B   = 2'd2;
  localparam logic [1:0] SEND_TRL = 2'd3;

  logic [1:0]                   state;
  logic [IW-1:0]                idx;
  logic [NUM_BINS*CNT_SIZE-1:0] addr_sh;
  logic [NUM_BINS*CNT_SIZE-1:0] vctr_sh;
  logic [7:0]                   seq;
  logic [15:0]                  drop_cnt;
  logic [15:0]                  trl_drop;
  logic                         first_bank;

  logic                trig;
  logic                accept;
  logic                idx_last;
  logic                is_vctr;
  logic [CNT_SIZE-1:0] bin;
  logic [15:0]         drop_inc;
  logic [15:0]         drop_nxt;

  assign trig     = end_program | host_req;
  assign busy     = (state != IDLE);
  assign out_valid = busy;
  assign out_last = (state == SEND_TRL);
  assign accept   = out_valid & out_ready;
  assign idx_last = (idx == IW'(NUM_BINS - 1));
  assign is_vctr  = (state == SEND_B) ^ first_bank;
  assign bin      = is_vctr ? vctr_sh[idx*CNT_SIZE +: CNT_SIZE]
                            : addr_sh[idx*CNT_SIZE +: CNT_SIZE];
  assign drop_inc = (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;
  assign drop_nxt = (busy && trig) ? drop_inc : drop_cnt;

  always_comb begin
    out_data = 32'd0;
    unique case (1'b1)
      (state == IDLE):     out_data = 32'd0;
      (state == SEND_TRL): out_data = {8'hFF, seq, trl_drop};
      default: out_data = {is_vctr ? 8'h0B : 8'h0A, 8'(idx), 16'(bin)};
    endcase
  end

  // Trailer count is frozen when the trailer is first presented so the
  // word stays stable under back-pressure.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      addr_sh    <= '0;
      vctr_sh    <= '0;
      seq        <= 8'd0;
      drop_cnt   <= 16'd0;
      trl_drop   <= 16'd0;
      first_bank <= 1'b0;
      done       <= 1'b0;
    end else begin
      done     <= 1'b0;
      drop_cnt <= drop_nxt;
      case (state)
        IDLE: begin
          if (trig) begin
            addr_sh <= addr_bins;
            vctr_sh <= vctr_bins;
            idx     <= '0;
            state   <= SEND_A;
          end
        end
        SEND_A: begin
          if (accept) begin
            if (idx_last) begin
              idx   <= '0;
              state <= SEND_B;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        SEND_B: begin
          if (accept) begin
            if (idx_last) begin
              idx      <= '0;
              state    <= SEND_TRL;
              trl_drop <= drop_nxt;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        SEND_TRL: begin
          if (accept) begin
            state      <= IDLE;
            done       <= 1'b1;
            seq        <= seq + 8'd1;
            first_bank <= ~first_bank;
            drop_cnt   <= {15'd0, trig};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_monitor_readout_ctrl.sv
// Randomised and directed bench for monitor_readout_ctrl against a
// queue-based model of the readout stream.
module tb_monitor_readout_ctrl;

  localparam int NB = 16;
  localparam int CS = 16;
  localparam int W  = NB * CS;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          end_program = 1'b0;
  logic          host_req = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  addr_bins = '0;
  logic [W-1:0]  vctr_bins = '0;
  logic          out_valid;
  logic [31:0]   out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  monitor_readout_ctrl #(.NUM_BINS(NB), .CNT_SIZE(CS)) dut (
    .clk(clk), .reset(reset),
    .end_program(end_program), .host_req(host_req),
    .addr_bins(addr_bins), .vctr_bins(vctr_bins),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int vcyc = 0;
  int done_cnt = 0;
  int trl_cyc = 0;
  int done_cyc = 0;
  logic [31:0] acc_log[$];

  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  bit          m_fb = 1'b0;
  bit          m_trig;
  logic [7:0]  m_seq = 8'd0;
  int          m_drop = 0;
  int          m_trl = 0;
  logic [31:0] q[$];
  logic [31:0] exp_w;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic load_model();
    bit v;
    for (int b = 0; b < 2; b++) begin
      v = (b == 1) ^ m_fb;
      for (int i = 0; i < NB; i++)
        q.push_back({v ? 8'h0B : 8'h0A, 8'(i),
                     16'(v ? vctr_bins[i*CS +: CS] : addr_bins[i*CS +: CS])});
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("out_valid", 32'(out_valid), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    if (m_busy) begin
      exp_w = (q.size() > 0) ? q[0] : {8'hFF, m_seq, 16'(m_trl)};
      chk("out_data", out_data, exp_w);
      chk("out_last", 32'(out_last), 32'(q.size() == 0));
    end
    if (out_valid) vcyc++;
    if (out_valid && out_ready) begin
      acc_log.push_back(out_data);
      if (out_last) trl_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    m_trig = end_program | host_req;
    if (!reset) begin
      m_busy = 0; m_done = 0; m_fb = 0; m_seq = 8'd0;
      m_drop = 0; m_trl = 0; q.delete();
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (m_trig) begin
          load_model();
          m_busy = 1;
        end
      end else begin
        if (m_trig && m_drop < 65535) m_drop++;
        if (out_ready) begin
          if (q.size() > 0) begin
            void'(q.pop_front());
            if (q.size() == 0) m_trl = m_drop;
          end else begin
            m_busy = 0; m_done = 1; m_seq++; m_fb = !m_fb;
            m_drop = m_trig ? 1 : 0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(int max_cyc);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < max_cyc) begin
      step();
      n++;
    end
    if (done_cnt == d0) begin
      n_chk++;
      n_err++;
      $display("FAIL wait_done: no done within %0d cycles", max_cyc);
    end
  endtask

  task automatic pulse_ep();
    end_program = 1'b1;
    step();
    end_program = 1'b0;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < NB; i++) begin
      addr_bins[i*CS +: CS] = CS'(i);
      vctr_bins[i*CS +: CS] = CS'(16'h100 + i);
    end
  endtask

  int base;
  int v0;
  int d0;
  int n;
  logic [31:0] w;

  initial begin
    repeat (3) step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", out_data, 32'd0);
    reset = 1'b1;
    set_ramp();
    out_ready = 1'b1;
    step();

    base = acc_log.size(); v0 = vcyc;
    pulse_ep();
    chk("t1_lat", 32'(out_valid), 32'd1);
    wait_done(200);
    chk("t1_words", 32'(acc_log.size() - base), 32'd33);
    chk("t1_w0", acc_log[base], 32'h0A00_0000);
    chk("t1_w15", acc_log[base+15], 32'h0A0F_000F);
    chk("t1_w16", acc_log[base+16], 32'h0B00_0100);
    chk("t1_w31", acc_log[base+31], 32'h0B0F_010F);
    chk("t1_trl", acc_log[base+32], 32'hFF00_0000);
    chk("t1_cycles", 32'(vcyc - v0), 32'd33);
    chk("t1_done_lat", 32'(done_cyc - trl_cyc), 32'd1);

    base = acc_log.size();
    host_req = 1'b1;
    step();
    host_req = 1'b0;
    wait_done(200);
    chk("t2_first", acc_log[base], 32'h0B00_0100);
    chk("t2_second", acc_log[base+16], 32'h0A00_0000);
    chk("t2_trl", acc_log[base+32], 32'hFF01_0000);

    base = acc_log.size(); v0 = vcyc; d0 = done_cnt;
    out_ready = 1'b0;
    pulse_ep();
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      out_ready = ~out_ready;
      step();
      n++;
    end
    chk("t3_done", 32'(done_cnt - d0), 32'd1);
    chk("t3_words", 32'(acc_log.size() - base), 32'd33);
    chk("t3_cycles", 32'(vcyc - v0), 32'd65);
    chk("t3_w0", acc_log[base], 32'h0A00_0000);
    chk("t3_trl", acc_log[base+32], 32'hFF02_0000);
    out_ready = 1'b1;

    pulse_ep();
    repeat (3) step();
    host_req = 1'b1;
    repeat (5) step();
    host_req = 1'b0;
    wait_done(200);
    w = acc_log[acc_log.size()-1];
    chk("t4_drop5", w, 32'hFF03_0005);
    pulse_ep();
    wait_done(200);
    w = acc_log[acc_log.size()-1];
    chk("t4_drop0", w, 32'hFF04_0000);

    base = acc_log.size();
    pulse_ep();
    repeat (5) step();
    for (int i = 0; i < NB; i++) begin
      addr_bins[i*CS +: CS] = CS'($urandom);
      vctr_bins[i*CS +: CS] = CS'($urandom);
    end
    wait_done(200);
    for (int i = 0; i < 32; i++) begin
      w = acc_log[base+i];
      if (w[31:24] == 8'h0A) chk("t5_snap", 32'(w[15:0]), 32'(w[23:16]));
      else chk("t5_snap_v", 32'(w[15:0]), 32'h100 + 32'(w[23:16]));
    end
    set_ramp();

    base = acc_log.size(); d0 = done_cnt;
    pulse_ep();
    n = 0;
    while (acc_log.size() - base < 10 && n < 100) begin
      step();
      n++;
    end
    reset = 1'b0;
    step();
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    step();
    chk("t6_nodone", 32'(done_cnt - d0), 32'd0);
    base = acc_log.size();
    pulse_ep();
    wait_done(200);
    chk("t6_w0", acc_log[base], 32'h0A00_0000);
    chk("t6_trl", acc_log[base+32], 32'hFF00_0000);

    for (int c = 0; c < 4000; c++) begin
      end_program = ($urandom_range(0, 19) == 0);
      host_req    = ($urandom_range(0, 24) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      reset       = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 9) == 0) begin
        for (int i = 0; i < NB; i++) begin
          addr_bins[i*CS +: CS] = CS'($urandom);
          vctr_bins[i*CS +: CS] = CS'($urandom);
        end
      end
      step();
    end
    end_program = 1'b0;
    host_req = 1'b0;
    reset = 1'b1;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/monitor_readout_ctrl.md
MONITOR_READOUT_CTRL -- requirements
Module: monitor_readout_ctrl

Interface
REQ-001 SHALL have parameter NUM_BINS, default 16, histogram bins per bank.
REQ-002 SHALL have parameter CNT_SIZE, default 16, bits per bin count; legal range 1..16.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port end_program  input  1  readout trigger, level sampled each cycle.
REQ-006 SHALL have port host_req  input  1  readout trigger, level sampled each cycle.
REQ-007 SHALL have port addr_bins  input  NUM_BINS*CNT_SIZE  address histogram, bin i at [i*CNT_SIZE +: CNT_SIZE].
REQ-008 SHALL have port vctr_bins  input  NUM_BINS*CNT_SIZE  vector histogram, same packing.
REQ-009 SHALL have port out_valid  output  1  stream word valid.
REQ-010 SHALL have port out_ready  input  1  downstream accept.
REQ-011 SHALL have port out_data  output  32  stream word.
REQ-012 SHALL have port out_last  output  1  marks trailer word.
REQ-013 SHALL have port busy  output  1  high when state != IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse after trailer accepted.

Function
REQ-015 SHALL implement states IDLE, SEND_A, SEND_B, SEND_TRL.
REQ-016 SHALL, in IDLE, start a readout when end_program OR host_req is high; both high same cycle = one readout.
REQ-017 SHALL, on the start edge, copy addr_bins and vctr_bins into shadow registers and zero bin index; all bin words come from shadows.
REQ-018 SHALL assert out_valid the cycle after the trigger (latency 1).
REQ-019 SHALL order banks per readout using first_bank flag: 0 = address bank then vector bank, 1 = reverse; SEND_A streams first bank, SEND_B second.
REQ-020 SHALL toggle first_bank when the trailer is accepted (round-robin).
REQ-021 SHALL format bin words: [31:24] = 0x0A address or 0x0B vector, [23:16] = bin index, [15:0] = count zero-extended.
REQ-022 SHALL advance only on out_valid AND out_ready; index NUM_BINS-1 accepted -> next state, index back to 0.
REQ-023 SHALL hold out_data, out_last, out_valid stable while out_valid high and out_ready low.
REQ-024 SHALL emit trailer in SEND_TRL: [31:24] = 0xFF, [23:16] = seq, [15:0] = drop_cnt, out_last = 1.
REQ-025 SHALL return to IDLE on trailer acceptance and pulse done in the following cycle; seq increments then, wrapping 0xFF -> 0x00.
REQ-026 SHALL count in drop_cnt each cycle with a trigger high while not IDLE, saturating at 0xFFFF.
REQ-027 SHALL clear drop_cnt on trailer acceptance; a trigger in that same cycle loads drop_cnt = 1.
REQ-028 SHALL not start a new readout in the done cycle unless a trigger is high then; back-to-back readouts permitted.
REQ-029 SHALL emit exactly 2*NUM_BINS+1 words per readout; minimum 2*NUM_BINS+1 cycles with out_ready tied high.

Reset
REQ-030 SHALL, with reset low at a clock edge, force IDLE and clear out_valid, out_last, out_data, busy, done, seq, drop_cnt, first_bank, index, shadows, regardless of state.
REQ-031 SHALL abandon an in-progress readout on reset, with no trailer and no done.

Verification
REQ-032 Bins addr[i]=i, vctr[i]=0x100+i, end_program pulse, ready high -> 33 words: 0x0A00_0000..0x0A0F_000F, 0x0B00_0100..0x0B0F_010F, 0xFF00_0000 with last; done next cycle.
REQ-033 Second readout via host_req -> vector bank first (0x0B tags), trailer seq=0x01.
REQ-034 Ready toggled 1/0 per cycle -> out_data stable while stalled, no word lost or duplicated, 65 cycles total.
REQ-035 Trigger held high 5 cycles during busy -> trailer [15:0]=0x0005; next readout trailer 0x0000.
REQ-036 addr_bins changed mid-readout -> streamed counts equal trigger-cycle values.
REQ-037 Reset low at word 10 -> next cycle out_valid=0, busy=0; subsequent readout starts with address bank, seq=0x00.
